pattern_scan_ctrl: RTL and testbench



---
 rtl/pattern_pkg.sv | 29 ++
 rtl/pattern_out_fifo.sv | 84 ++++++++
 rtl/pattern_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
// Shared types and constants for the raster-scan sequencer that feeds the
// RGB565 test-pattern generator.
//   - scan_state_e : sequencer FSM states
//   - PIX_W        : RGB565 pixel width
//   - COORD_W      : pic_x / pic_y width
//   - FIFO_DEPTH   : entries in the output FIFO
//   - FIFO_W       : FIFO entry width, {sof, eol, pixel}
// ---------------------------------------------------------------------------
package pattern_pkg;

    localparam int PIX_W         = 16;
    localparam int COORD_W       = 12;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int FRAME_GAP_DEF = 16;
    localparam int FIFO_DEPTH    = 4;
    localparam int FIFO_W        = PIX_W + 2;
    localparam int FIFO_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } scan_state_e;

endpackage

// File: rtl/pattern_out_fifo.sv
// ---------------------------------------------------------------------------
// pattern_out_fifo
// Small first-word-fall-through FIFO holding captured pixels with their
// start-of-frame / end-of-line tags. The head entry is always visible on
// data_o while the FIFO is not empty.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write data_i at the end of this cycle
//   data_i       : {sof, eol, pixel}
//   pop_i        : drop the head entry at the end of this cycle
//   data_o       : head entry
//   empty_o      : no entries stored
//   count_o      : current occupancy (before this cycle's push/pop)
// ---------------------------------------------------------------------------
module pattern_out_fifo
    import pattern_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [FIFO_W-1:0]     data_i,
    input  logic                  pop_i,
    output logic [FIFO_W-1:0]     data_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [FIFO_W-1:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wrPtr_q;
    logic [FIFO_PTR_W-1:0] rdPtr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic [FIFO_CNT_W-1:0] count_d;
    logic                  full;
    logic                  popEn;
    logic                  pushEn;

    assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A pop on an empty FIFO is ignored. A push into a full FIFO is only
    // accepted when the head leaves in the same cycle, which frees the slot
    // the write pointer is sitting on.
    assign popEn  = pop_i && !empty_o;
    assign pushEn = push_i && (!full || popEn);

    // Occupancy only moves when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (!pushEn && popEn) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and pointers. The array is cleared on reset so the head reads
    // as zero before anything has been written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // The issue throttle upstream guarantees there is always room.
    overflowCheck: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !popEn));

endmodule

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
// Raster-scan sequencer for the RGB565 test-pattern generator. Presents
// coordinates to the generator, captures its registered output one cycle
// later into a 4-entry FIFO and streams frames out with valid/ready plus
// start-of-frame / end-of-line sideband.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : start / continue frames while high
//   pic_x, pic_y      : coordinate presented to the generator
//   pic_data          : generator pixel, valid the cycle after pic_x/pic_y
//   m_data            : RGB565 output pixel
//   m_valid, m_ready  : output handshake
//   m_sof, m_eol      : pixel (0,0) / last pixel of a line
//   frame_done        : pulse after the last pixel of a frame is accepted
//   busy              : FSM not idle or FIFO holding pixels
// ---------------------------------------------------------------------------
module pattern_scan_ctrl
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FRAME_GAP = FRAME_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic [COORD_W-1:0] pic_x,
    output logic [COORD_W-1:0] pic_y,
    input  logic [PIX_W-1:0]   pic_data,
    output logic [PIX_W-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sof,
    output logic               m_eol,
    output logic               frame_done,
    output logic               busy
);

    localparam int                 GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(FRAME_GAP - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);

    scan_state_e           state_q, state_d;
    logic [GAP_W-1:0]      gapCnt_q, gapCnt_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]    outY_q, outY_d;
    logic                  issued_q, sof_q, eol_q;
    logic                  frameDone_q, frameDone_d;
    logic [FIFO_CNT_W-1:0] fifoCount;
    logic [FIFO_W-1:0]     fifoHead;
    logic                  fifoEmpty;
    logic                  issue, lastPix, pop;

    // Counting the pixel still in the generator pipe keeps FIFO plus
    // in-flight at or below the depth. Occupancy is taken before this
    // cycle's pop, which costs nothing at full rate and can never overflow.
    assign issue   = (state_q == ACTIVE) &&
                     (({1'b0, fifoCount} + (FIFO_CNT_W + 1)'(issued_q)) <
                      (FIFO_CNT_W + 1)'(FIFO_DEPTH));
    assign lastPix = (x_q == X_LAST) && (y_q == Y_LAST);
    assign pop     = m_valid && m_ready;

    assign pic_x      = x_q;
    assign pic_y      = y_q;
    assign m_valid    = !fifoEmpty;
    assign m_sof      = fifoHead[FIFO_W-1];
    assign m_eol      = fifoHead[FIFO_W-2];
    assign m_data     = fifoHead[PIX_W-1:0];
    assign frame_done = frameDone_q;
    assign busy       = (state_q != IDLE) || !fifoEmpty;

    // Frame sequencing: a frame ends when its last coordinate is issued,
    // then the gap runs down before enable decides whether to start again.
    // Dropping enable mid-frame is ignored because ACTIVE never looks at it.
    always_comb begin
        state_d  = state_q;
        gapCnt_d = gapCnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (issue && lastPix) begin
                    state_d  = GAP;
                    gapCnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (gapCnt_q == '0) begin
                    state_d = enable ? ACTIVE : IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster advance; coordinates hold whenever nothing is issued.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (issue) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // The output side tracks which line is leaving so the final eol of the
    // frame can be recognised without widening the FIFO entries.
    always_comb begin
        outY_d      = outY_q;
        frameDone_d = 1'b0;
        if (pop && m_eol) begin
            if (outY_q == Y_LAST) begin
                outY_d      = '0;
                frameDone_d = 1'b1;
            end else begin
                outY_d = outY_q + 1'b1;
            end
        end
    end

    // State registers. The sof/eol tags are delayed one cycle so they line
    // up with the generator's registered pixel when it is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gapCnt_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            outY_q      <= '0;
            issued_q    <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gapCnt_q    <= gapCnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            outY_q      <= outY_d;
            issued_q    <= issue;
            sof_q       <= issue && (x_q == '0) && (y_q == '0);
            eol_q       <= issue && (x_q == X_LAST);
            frameDone_q <= frameDone_d;
        end
    end

    pattern_out_fifo uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issued_q),
        .data_i  ({sof_q, eol_q, pic_data}),
        .pop_i   (pop),
        .data_o  (fifoHead),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Directed bench for the raster-scan sequencer on a 4x3 frame. A registered
// diamond-pattern generator stands in for color_data; every beat is compared
// against that pattern at the raster position the bench expects next.
// ---------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int GAPC = 16;
    localparam int NPIX = H * V;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        m_ready = 1'b0;
    logic [11:0] pic_x;
    logic [11:0] pic_y;
    logic [15:0] pic_data;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_sof;
    logic        m_eol;
    logic        frame_done;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    pattern_scan_ctrl #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FRAME_GAP (GAPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pic_x      (pic_x),
        .pic_y      (pic_y),
        .pic_data   (pic_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Cycle stamp used for latency measurements.
    always @(posedge clk) cycle <= cycle + 1;

    // Diamond test pattern: Manhattan distance from the frame centre in the
    // top bits, raw x and y below so every position has a distinct value.
    function automatic logic [15:0] genPix(input int x, input int y);
        int dx, dy, d;
        dx = (x >= H / 2) ? x - H / 2 : H / 2 - x;
        dy = (y >= V / 2) ? y - V / 2 : V / 2 - y;
        d  = dx + dy;
        return {d[4:0], x[5:0], y[4:0]};
    endfunction

    // Stand-in for the generator: one register stage from coordinate to pixel.
    always @(posedge clk) pic_data <= genPix(int'(pic_x), int'(pic_y));

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs sit at their reset values while rst_n is low, whatever the inputs.
    task automatic test_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        repeat (4) step();
        testsRun++; if (pic_x !== 12'd0) begin testsFailed++; $display("[TB] FAIL reset_pic_x: got %0d want 0", pic_x); end
        testsRun++; if (pic_y !== 12'd0) begin testsFailed++; $display("[TB] FAIL reset_pic_y: got %0d want 0", pic_y); end
        testsRun++; if (m_data !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_m_data: got %h want 0000", m_data); end
        testsRun++; if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
        testsRun++; if (m_sof !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_m_sof: got %b want 0", m_sof); end
        testsRun++; if (m_eol !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_m_eol: got %b want 0", m_eol); end
        testsRun++; if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (2) step();
    endtask

    // One frame from a single-cycle enable pulse with m_ready held high.
    task automatic test_single_frame();
        int b;
        m_ready = 1'b1;
        enable  = 1'b1;
        step();
        enable = 1'b0;
        testsRun++; if (pic_x !== 12'd0 || pic_y !== 12'd0) begin testsFailed++; $display("[TB] FAIL start_coord: got (%0d,%0d) want (0,0)", pic_x, pic_y); end
        testsRun++; if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL start_valid_c1: got %b want 0", m_valid); end
        step();
        testsRun++; if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL start_valid_c2: got %b want 0", m_valid); end
        step();
        for (b = 0; b < NPIX; b++) begin
            testsRun++;
            if (m_valid !== 1'b1 || m_data !== genPix(b % H, b / H) ||
                m_sof !== (b == 0) || m_eol !== ((b % H) == H - 1)) begin
                testsFailed++;
                $display("[TB] FAIL single_beat%0d: got v=%b d=%h sof=%b eol=%b want v=1 d=%h sof=%b eol=%b",
                         b + 1, m_valid, m_data, m_sof, m_eol, genPix(b % H, b / H), (b == 0), ((b % H) == H - 1));
            end
            step();
        end
        testsRun++; if (frame_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_frame_done: got %b want 1", frame_done); end
        step();
        testsRun++; if (frame_done !== 1'b0 || m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_after_done: got done=%b valid=%b want 0 0", frame_done, m_valid); end
        // Last issue in cycle 12, gap in 13..28, idle from cycle 29; we are in cycle 16.
        b = 0;
        while (busy === 1'b1 && b < 60) begin
            step();
            b++;
        end
        testsRun++; if (b != 13) begin testsFailed++; $display("[TB] FAIL single_idle_time: got %0d cycles want 13", b); end
        repeat (10) step();
        testsRun++; if (m_valid !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_stays_idle: got valid=%b busy=%b want 0 0", m_valid, busy); end
    endtask

    // enable held high: two frames back to back with the fixed gap between.
    task automatic test_back_to_back();
        int b, idx, guard, lastIssueCyc, sofCyc;
        b            = 0;
        lastIssueCyc = -1;
        sofCyc       = -1;
        m_ready      = 1'b1;
        enable       = 1'b1;
        for (guard = 0; guard < 300 && b < 2 * NPIX; guard++) begin
            step();
            if (pic_x == 12'(H - 1) && pic_y == 12'(V - 1) && sofCyc < 0) lastIssueCyc = cycle;
            if (m_valid === 1'b1) begin
                idx = b % NPIX;
                testsRun++;
                if (m_data !== genPix(idx % H, idx / H) || m_sof !== (idx == 0) || m_eol !== ((idx % H) == H - 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_beat%0d: got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                             b + 1, m_data, m_sof, m_eol, genPix(idx % H, idx / H), (idx == 0), ((idx % H) == H - 1));
                end
                if (b == NPIX) begin
                    sofCyc = cycle;
                    enable = 1'b0;
                end
                b++;
            end else if ((b % NPIX) != 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL b2b_continuity: got valid=0 after beat %0d want 1", b);
            end
        end
        testsRun++; if (b != 2 * NPIX) begin testsFailed++; $display("[TB] FAIL b2b_beats: got %0d want %0d", b, 2 * NPIX); end
        testsRun++; if (sofCyc - lastIssueCyc != GAPC + 3) begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d cycles want %0d", sofCyc - lastIssueCyc, GAPC + 3); end
        guard = 0;
        while (busy === 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    // Downstream stalls for 10 cycles when beat 5 is offered.
    task automatic test_backpressure();
        int b, guard, stall, outst;
        bit stallDone;
        b         = 0;
        stall     = 0;
        stallDone = 1'b0;
        m_ready   = 1'b1;
        enable    = 1'b1;
        step();
        enable = 1'b0;
        for (guard = 0; guard < 200 && b < NPIX; guard++) begin
            if (b == 4 && m_valid === 1'b1 && !stallDone) begin
                stall     = 10;
                stallDone = 1'b1;
            end
            m_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (stall > 0) begin
                outst = int'(pic_y) * H + int'(pic_x) - b;
                testsRun++; if (outst < 0 || outst > 4) begin testsFailed++; $display("[TB] FAIL bp_outstanding: got %0d want 0..4", outst); end
                stall--;
                if (stall == 0) begin
                    testsRun++; if (pic_x !== 12'd0 || pic_y !== 12'd2) begin testsFailed++; $display("[TB] FAIL bp_coord_hold: got (%0d,%0d) want (0,2)", pic_x, pic_y); end
                end
            end
            if (m_valid === 1'b1) begin
                testsRun++;
                if (m_data !== genPix(b % H, b / H) || m_sof !== (b == 0) || m_eol !== ((b % H) == H - 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_beat%0d: got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                             b + 1, m_data, m_sof, m_eol, genPix(b % H, b / H), (b == 0), ((b % H) == H - 1));
                end
                if (m_ready) b++;
            end
            step();
        end
        m_ready = 1'b1;
        testsRun++; if (b != NPIX) begin testsFailed++; $display("[TB] FAIL bp_beats: got %0d want %0d", b, NPIX); end
        testsRun++; if (frame_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_frame_done: got %b want 1", frame_done); end
        step();
        testsRun++; if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_no_extra: got valid=%b want 0", m_valid); end
        guard = 0;
        while (busy === 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_idle: got busy=%b want 0", busy); end
    endtask

    // enable falls at beat 3; the frame still completes and no new one starts.
    task automatic test_enable_drop();
        int b, guard, extra;
        b       = 0;
        extra   = 0;
        m_ready = 1'b1;
        enable  = 1'b1;
        for (guard = 0; guard < 200 && b < NPIX; guard++) begin
            step();
            if (b == 2) enable = 1'b0;
            if (m_valid === 1'b1) begin
                testsRun++;
                if (m_data !== genPix(b % H, b / H) || m_sof !== (b == 0) || m_eol !== ((b % H) == H - 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_beat%0d: got d=%h sof=%b eol=%b want d=%h", b + 1, m_data, m_sof, m_eol, genPix(b % H, b / H));
                end
                b++;
            end
        end
        testsRun++; if (b != NPIX) begin testsFailed++; $display("[TB] FAIL drop_beats: got %0d want %0d", b, NPIX); end
        guard = 0;
        while (busy === 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_idle: got busy=%b want 0", busy); end
        for (int i = 0; i < 30; i++) begin
            step();
            if (m_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        testsRun++; if (extra != 0) begin testsFailed++; $display("[TB] FAIL drop_restart: got %0d active cycles want 0", extra); end
    endtask

    // Random backpressure, reset pulsed mid-frame, then one clean frame.
    task automatic test_reset_midframe();
        int b, guard, fdCount;
        logic [31:0] sum, expSum;
        b       = 0;
        enable  = 1'b1;
        for (guard = 0; guard < 300 && b < 6; guard++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid === 1'b1 && m_ready) b++;
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        testsRun++; if (m_valid !== 1'b0 || busy !== 1'b0 || pic_x !== 12'd0 || pic_y !== 12'd0) begin
            testsFailed++;
            $display("[TB] FAIL rst_async: got valid=%b busy=%b pic=(%0d,%0d) want 0 0 (0,0)", m_valid, busy, pic_x, pic_y);
        end
        step();
        step();
        rst_n   = 1'b1;
        b       = 0;
        fdCount = 0;
        sum     = '0;
        expSum  = '0;
        for (int i = 0; i < NPIX; i++) expSum += 32'(genPix(i % H, i / H));
        for (guard = 0; guard < 600 && b < NPIX; guard++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (frame_done === 1'b1) fdCount++;
            if (m_valid === 1'b1) begin
                enable = 1'b0;
                testsRun++;
                if (m_data !== genPix(b % H, b / H) || m_sof !== (b == 0) || m_eol !== ((b % H) == H - 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL rst_beat%0d: got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                             b + 1, m_data, m_sof, m_eol, genPix(b % H, b / H), (b == 0), ((b % H) == H - 1));
                end
                if (m_ready) begin
                    sum += 32'(m_data);
                    b++;
                end
            end
            step();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) fdCount++;
            step();
        end
        testsRun++; if (b != NPIX) begin testsFailed++; $display("[TB] FAIL rst_beats: got %0d want %0d", b, NPIX); end
        testsRun++; if (sum !== expSum) begin testsFailed++; $display("[TB] FAIL rst_checksum: got %h want %h", sum, expSum); end
        testsRun++; if (fdCount != 1) begin testsFailed++; $display("[TB] FAIL rst_frame_done_count: got %0d want 1", fdCount); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_idle: got busy=%b want 0", busy); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_enable_drop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Last-resort guard in case something stops the scenarios advancing.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
